// File: rtl/ram_load_router_pkg.sv
//------------------------------------------------------------------------------
// Module   : ram_load_router_pkg
// Purpose  : Shared state encodings and RAM index constants for the RAM load
//            router and its address/remaining counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_load_router_pkg;

   // Load sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Target RAM indices
   localparam int RAM_DATA   = 0;
   localparam int RAM_WEIGHT = 1;

endpackage : ram_load_router_pkg

`default_nettype wire

// File: rtl/ram_load_cnt.sv
//------------------------------------------------------------------------------
// Module   : ram_load_cnt
// Purpose  : Loadable write-address / remaining-word counter. The address
//            counts up and the remaining count counts down on every step;
//            last flags the final word of the load.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_load_cnt #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [ADDR_W:0]   load_len,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   C_REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_rem;

   // Load start address / word count, then advance once per accepted word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_rem  <= '0;
      end else if (load) begin
         r_addr <= load_addr;
         r_rem  <= load_len;
      end else if (step) begin
         r_addr <= r_addr + C_ADDR_ONE;
         r_rem  <= r_rem - C_REM_ONE;
      end
   end

   assign addr = r_addr;
   assign last = (r_rem == C_REM_ONE);

endmodule : ram_load_cnt

`default_nettype wire

// File: rtl/ram_load_router.sv
//------------------------------------------------------------------------------
// Module   : ram_load_router
// Purpose  : Routes a valid/ready word stream into one of NUM_RAM target RAMs
//            as a bounded, sequential write burst with abort and error report.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_load_router
   import ram_load_router_pkg::*;
#(
   parameter int NUM_RAM = 2,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 64,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int SEL_W   = (NUM_RAM > 2) ? $clog2(NUM_RAM) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SEL_W-1:0]   sel,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [ADDR_W:0]    len,
   input  logic               abort,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic [NUM_RAM-1:0] ram_en,
   output logic [ADDR_W-1:0]  ram_waddr,
   output logic [DATA_W-1:0]  ram_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [NUM_RAM-1:0] loaded
);

   // Bounds compared one bit wider than base+len so the sum cannot overflow
   localparam logic [ADDR_W+1:0] C_DEPTH   = (ADDR_W+2)'(DEPTH);
   localparam logic [SEL_W:0]    C_NUM_RAM = (SEL_W+1)'(NUM_RAM);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_sel;
   logic [NUM_RAM-1:0] r_loaded;
   logic               r_err;
   logic               w_accept;
   logic               w_start_ok;
   logic               w_start_bad;
   logic               w_last;
   logic [ADDR_W+1:0]  w_end;

   assign w_end = {2'b00, base_addr} + {1'b0, len};

   // Next-state decode, start qualification and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_start_bad = 1'b0;
      in_ready    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if ((len != '0) && ({1'b0, sel} < C_NUM_RAM) && (w_end <= C_DEPTH)) begin
                  w_start_ok  = 1'b1;
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_start_bad = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            busy     = 1'b1;
            in_ready = !abort;
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (in_valid && w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            busy        = 1'b1;
            done        = !abort;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_accept = in_valid && in_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Target latch, rejected-start pulse and per-RAM completion flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel    <= '0;
         r_err    <= 1'b0;
         r_loaded <= '0;
      end else begin
         r_err <= w_start_bad;
         if (w_start_ok) begin
            r_sel <= sel;
         end
         // Completion is committed on leaving DONE so an abort there leaves it clear
         for (int i = 0; i < NUM_RAM; i++) begin
            if (w_start_ok && (sel == SEL_W'(i))) begin
               r_loaded[i] <= 1'b0;
            end else if ((r_state == ST_DONE) && !abort && (r_sel == SEL_W'(i))) begin
               r_loaded[i] <= 1'b1;
            end
         end
      end
   end

   ram_load_cnt #(
      .ADDR_W (ADDR_W)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_start_ok),
      .load_addr (base_addr),
      .load_len  (len),
      .step      (w_accept),
      .addr      (ram_waddr),
      .last      (w_last)
   );

   // One-hot write enable for the latched target, active only on an accept
   for (genvar gi = 0; gi < NUM_RAM; gi++) begin : g_en
      assign ram_en[gi] = w_accept && (r_sel == SEL_W'(gi));
   end

   assign ram_wdata = in_data;
   assign err       = r_err;
   assign loaded    = r_loaded;

endmodule : ram_load_router

`default_nettype wire

// File: doc/ram_load_router.md
RAM_LOAD_ROUTER -- requirements
Module: ram_load_router

Interface
REQ-001 Parameter NUM_RAM, default 2: number of target RAMs; index 0 is data, index 1 is weight.
REQ-002 Parameter DATA_W, default 8: stream and RAM write-data width.
REQ-003 Parameter DEPTH, default 64: word depth of the largest target RAM.
REQ-004 Parameter ADDR_W, default $clog2(DEPTH): write-address width.
REQ-005 Parameter SEL_W, default max(1,$clog2(NUM_RAM)): target-select width.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  request a load; sampled only in IDLE.
REQ-009 sel  in  SEL_W  target RAM index, latched on accepted start.
REQ-010 base_addr  in  ADDR_W  first write address, latched on accepted start.
REQ-011 len  in  ADDR_W+1  word count, latched on accepted start.
REQ-012 abort  in  1  cancel the load in progress.
REQ-013 in_valid  in  1  stream word valid.
REQ-014 in_data  in  DATA_W  stream word.
REQ-015 in_ready  out  1  router accepts a word this cycle.
REQ-016 ram_en  out  NUM_RAM  one-hot RAM write enable.
REQ-017 ram_waddr  out  ADDR_W  write address shared by all RAMs.
REQ-018 ram_wdata  out  DATA_W  write data shared by all RAMs.
REQ-019 busy  out  1  high in LOAD and DONE.
REQ-020 done  out  1  one-cycle pulse when a load completes.
REQ-021 err  out  1  one-cycle pulse when a start is rejected.
REQ-022 loaded  out  NUM_RAM  per-RAM flag: last load to that RAM completed.

Function
REQ-023 States: IDLE, LOAD, DONE.
REQ-024 An accepted start requires all of the following: IDLE, start=1, len!=0, sel<NUM_RAM, and base_addr+len<=DEPTH computed at ADDR_W+2 bits.
REQ-025 On an accepted start the block latches sel, ram_waddr<=base_addr and remaining<=len, clears loaded[sel], and moves to LOAD next cycle.
REQ-026 A start in IDLE that fails REQ-024 causes err=1 the next cycle, and the state stays IDLE.
REQ-027 A start in LOAD or DONE is ignored without an err pulse.
REQ-028 in_ready=1 exactly when the state is LOAD and abort=0.
REQ-029 A word is accepted when in_valid and in_ready are both high in the same cycle.
REQ-030 ram_en[sel_q]=1 in the same cycle as the accept; all other ram_en bits are 0; ram_wdata=in_data combinationally, giving zero-cycle write latency.
REQ-031 On each accept, ram_waddr increments by 1 and remaining decrements by 1; ram_waddr never wraps because of REQ-024.
REQ-032 An accept with remaining==1 moves the state to DONE; in DONE, done=1 and loaded[sel_q] is set; the next state is IDLE.
REQ-033 A cycle with in_valid=0 during LOAD stalls the load: no write, no address change.
REQ-034 abort=1 in LOAD or DONE returns the state to IDLE next cycle, with no write that cycle, no done pulse and loaded unchanged; abort in IDLE has no effect.
REQ-035 If abort and the final accept coincide, abort wins: no write and no done.
REQ-036 ram_waddr holds its last value in IDLE.

Reset
REQ-037 While rst_n=0: state=IDLE, ram_waddr=0, remaining=0, sel_q=0, loaded=0, done=0, err=0, in_ready=0, ram_en=0.
REQ-038 Reset asserted mid-load discards the load immediately and asynchronously.

Structure
REQ-039 A shared package/header holds the state encodings (IDLE=0, LOAD=1, DONE=2) and the RAM index constants RAM_DATA=0 and RAM_WEIGHT=1.
REQ-040 A single sub-module, ram_load_cnt (loadable address/remaining counter with terminal flag), is natural; the FSM and one-hot decode stay in the top level.

Verification
REQ-041 Defaults; start with sel=0, base=0, len=64; in_valid held high -> 64 writes on ram_en=01, addresses 0..63; done pulses the cycle after address 63; loaded=01.
REQ-042 Start with sel=1, base=0, len=54; in_valid toggling every cycle -> exactly 54 writes on ram_en=10, addresses 0..53, no write on invalid cycles; loaded=11.
REQ-043 Start with base=60, len=5 -> err pulse, no busy, no ram_en; start with len=0 -> err pulse; start with sel=2 (NUM_RAM=2, SEL_W=1 unaffected; test with NUM_RAM=3) -> err pulse.
REQ-044 Load sel=0, base=8, len=10; abort after 4 accepts -> writes at addresses 8..11 only, IDLE next cycle, no done, loaded[0]=0.
REQ-045 Assert rst_n=0 mid-load after 3 writes -> all outputs at REQ-037 values asynchronously; a subsequent start with base=0, len=2 completes normally.
REQ-046 Start pulse during LOAD -> ignored, no err pulse; the current load's address sequence is unaffected.
